// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU between two requesters.
// Optional divide-by-zero trapping is enabled by defining ALU_ARB_DIVZERO_EN.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] req0_in0,
  input  logic [3:0] req0_in1,
  input  logic [2:0] req0_sel,
  input  logic       req1,
  input  logic [3:0] req1_in0,
  input  logic [3:0] req1_in1,
  input  logic [2:0] req1_sel,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] alu_in0,
  output logic [3:0] alu_in1,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_out,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_err,
  input  logic       rsp_ready,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic [3:0] alu_in0_q, alu_in0_d;
  logic [3:0] alu_in1_q, alu_in1_d;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic [3:0] exec_data;
  logic       win;

`ifdef ALU_ARB_DIVZERO_EN
  logic rsp_err_q, rsp_err_d;
  logic div_zero;

  assign div_zero  = (alu_sel_q == 3'b011) && (alu_in1_q == 4'h0);
  assign exec_data = div_zero ? 4'hF : alu_out;

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (state_q == StExec) rsp_err_d = div_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_err_q <= 1'b0;
    else     rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;
`else
  assign exec_data = alu_out;
  assign rsp_err   = 1'b0;
`endif

  // Lone request wins; on contention the pointer decides.
  assign win = (req0 && req1) ? ptr_q : req1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    alu_in0_d   = alu_in0_q;
    alu_in1_d   = alu_in1_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d  = StExec;
          ptr_d    = ~win;
          rsp_id_d = win;
          if (win) begin
            gnt1_d    = 1'b1;
            alu_in0_d = req1_in0;
            alu_in1_d = req1_in1;
            alu_sel_d = req1_sel;
          end else begin
            gnt0_d    = 1'b1;
            alu_in0_d = req0_in0;
            alu_in1_d = req0_in1;
            alu_sel_d = req0_sel;
          end
        end
      end
      StExec: begin
        rsp_data_d  = exec_data;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      alu_in0_q   <= 4'h0;
      alu_in1_q   <= 4'h0;
      alu_sel_q   <= 3'h0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      alu_in0_q   <= alu_in0_d;
      alu_in1_q   <= alu_in1_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign alu_in0   = alu_in0_q;
  assign alu_in1   = alu_in1_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule
